// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants for the bit-serial adder controller
// Purpose: FSM state encoding and counter sizing shared by the serial adder files.
// Ports:   none (package).
package serial_add_pkg;

    // Widest operand supported; the bit counter is sized to cover it.
    localparam int MAX_WIDTH = 32;
    localparam int CNT_W     = $clog2(MAX_WIDTH);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle for the serial adder controller
// Purpose: groups the operation request, operands and result handshake.
// Signals: start, A, B, sub (only with SERIAL_ADD_SUB_EN), ack  -- master to slave
//          busy, done, sum, carry                                -- slave to master
// Macro:   SERIAL_ADD_SUB_EN adds the sub select line.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, A, B, sub, ack, input busy, done, sum, carry);
    modport slave  (input start, A, B, sub, ack, output busy, done, sum, carry);
`else
    modport master (output start, A, B, ack, input busy, done, sum, carry);
    modport slave  (input start, A, B, ack, output busy, done, sum, carry);
`endif

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// rtl/serial_add_ctrl_fa_cell.sv - one-bit full adder from two half adders
// Purpose: the single arithmetic resource of the serial adder.
// ha ports:      a, b -> s, c
// fa_cell ports: a, b, cin -> s, cout
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    ha u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    ha u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add (optional subtract) controller
// Purpose: accepts A/B on start, adds them LSB first over WIDTH cycles through
//          one fa_cell, then presents sum/carry with done until ack.
// Ports:   clk, rst_n (async active-low), bus (serial_add_ctrl_if.slave).
// Macro:   SERIAL_ADD_SUB_EN enables subtract via bus.sub (B inverted, carry preset).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    // a_sh doubles as the sum accumulator: each RUN cycle consumes its LSB
    // and shifts the new sum bit in at the MSB.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             cy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;

    logic             b_bit;
    logic             fa_s;
    logic             fa_co;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_r;
    assign b_bit = b_sh[0] ^ sub_r;
`else
    assign b_bit = b_sh[0];
`endif

    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_bit),
        .cin  (cy),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            cy      <= 1'b0;
            cnt     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        sub_r <= bus.sub;
                        // A + ~B + 1: the +1 enters as the initial carry.
                        cy    <= bus.sub;
`else
                        cy    <= 1'b0;
`endif
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh <= {fa_s, a_sh[WIDTH-1:1]};
                    b_sh <= b_sh >> 1;
                    cy   <= fa_co;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        sum_r   <= {fa_s, a_sh[WIDTH-1:1]};
                        carry_r <= fa_co;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != S_IDLE);
    assign bus.done  = (state == S_DONE);
    assign bus.sum   = sum_r;
    assign bus.carry = carry_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8)
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic tb_sub;

    int n_chk  = 0;
    int n_fail = 0;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

`ifdef SERIAL_ADD_SUB_EN
    assign bus.sub = tb_sub;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks operation phase by counting cycles and computes
    // the result with plain arithmetic at acceptance time.
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic [W-1:0] m_sum   = '0;
    logic         m_carry = 1'b0;
    logic [W-1:0] m_psum  = '0;
    logic         m_pc    = 1'b0;
    int           m_left  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_sum = '0; m_carry = 0; m_left = 0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy = 1;
                m_left = W;
                if (tb_sub) begin
                    m_psum = bus.A - bus.B;
                    m_pc   = (bus.A >= bus.B);
                end else begin
                    m_psum = W'((int'(bus.A) + int'(bus.B)) % 256);
                    m_pc   = (int'(bus.A) + int'(bus.B)) >= 256;
                end
            end
        end else if (!m_done) begin
            m_left--;
            if (m_left == 0) begin
                m_done  = 1;
                m_sum   = m_psum;
                m_carry = m_pc;
            end
        end else if (bus.ack) begin
            m_busy = 0;
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_busy",  bus.busy,  m_busy);
            check("model_done",  bus.done,  m_done);
            check("model_sum",   bus.sum,   m_sum);
            check("model_carry", bus.carry, m_carry);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("wait_idle", bus.busy, 1'b0);
    endtask

    // Issues one operation, checks latency and result, stalls, then acks.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [W-1:0] es, input logic ec, input int stall);
        int n;
        wait_idle();
        @(posedge clk); #1;
        bus.start = 1; bus.A = a; bus.B = b; tb_sub = s;
        @(posedge clk); #1;
        // operands change after acceptance; result must not be affected
        bus.start = 0; bus.A = W'($urandom); bus.B = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        tb_sub = 1'($urandom);
`endif
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("latency", n, W);
        check("op_sum", bus.sum, es);
        check("op_carry", bus.carry, ec);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_done", bus.done, 1'b1);
            check("stall_sum", bus.sum, es);
            check("stall_carry", bus.carry, ec);
        end
        bus.ack = 1;
        @(posedge clk); #1;
        bus.ack = 0;
        tb_sub = 0;
        check("ack_idle", bus.busy, 1'b0);
    endtask

    initial begin
        int n;
        rst_n = 0; bus.start = 0; bus.A = '0; bus.B = '0; bus.ack = 0; tb_sub = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sum", bus.sum, 0);
        check("rst_carry", bus.carry, 1'b0);
        rst_n = 1;

        op(8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 0);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 20);
`ifdef SERIAL_ADD_SUB_EN
        op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 0);
        op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 0);
`endif

        // start held high through RUN and DONE, then ack+start together
        wait_idle();
        @(posedge clk); #1;
        bus.start = 1; bus.A = 8'h10; bus.B = 8'h20;
        @(posedge clk); #1;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("held_latency", n, W);
        check("held_sum", bus.sum, 8'h30);
        repeat (3) begin
            @(posedge clk); #1;
            check("held_single_done", bus.done, 1'b1);
        end
        bus.ack = 1; bus.A = 8'h28; bus.B = 8'h02;
        @(posedge clk); #1;
        bus.ack = 0;
        check("ackstart_idle", bus.busy, 1'b0);
        @(posedge clk); #1;
        bus.start = 0;
        check("second_accepted", bus.busy, 1'b1);
        n = 0;
        while (!bus.done && n < 40) begin
            check("prior_sum_held", bus.sum, 8'h30);
            @(posedge clk); #1; n++;
        end
        check("second_latency", n, W);
        check("second_sum", bus.sum, 8'h2A);
        bus.ack = 1;
        @(posedge clk); #1;
        bus.ack = 0;

        // reset mid-RUN
        wait_idle();
        @(posedge clk); #1;
        bus.start = 1; bus.A = 8'h01; bus.B = 8'h02;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("midrun_rst_busy", bus.busy, 1'b0);
        check("midrun_rst_done", bus.done, 1'b0);
        check("midrun_rst_sum", bus.sum, 0);
        check("midrun_rst_carry", bus.carry, 1'b0);
        #1 rst_n = 1;
        repeat (15) begin
            @(posedge clk); #1;
            check("no_done_after_rst", bus.done, 1'b0);
        end
        op(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 0);

        // randomized traffic, checked by the model every cycle
        repeat (1500) begin
            @(posedge clk); #1;
            bus.start = 1'($urandom);
            bus.ack   = ($urandom_range(0, 2) == 0);
            bus.A     = W'($urandom);
            bus.B     = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            tb_sub    = 1'($urandom);
`endif
        end
        bus.start = 0; bus.ack = 1;
        wait_idle();
        bus.ack = 0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand width in bits; legal values are 2 to 32.
REQ-002 clk  input  1  The block SHALL use this single rising-edge clock for all state.
REQ-003 rst_n  input  1  Reset SHALL be asynchronous and active-low.
REQ-004 start  input  1  This SHALL be the operation request, accepted only in IDLE.
REQ-005 A  input  WIDTH  This SHALL be operand A, sampled on the accepting edge.
REQ-006 B  input  WIDTH  This SHALL be operand B, sampled on the accepting edge.
REQ-007 sub  input  1  This SHALL select subtract, sampled on the accepting edge; present only with SERIAL_ADD_SUB_EN.
REQ-008 ack  input  1  This SHALL be the consumer acknowledge of a result.
REQ-009 busy  output  1  This SHALL be high in RUN and DONE.
REQ-010 done  output  1  This SHALL be high in DONE, marking sum/carry as a fresh result.
REQ-011 sum  output  WIDTH  This SHALL be the registered result, modulo 2^WIDTH.
REQ-012 carry  output  1  This SHALL be the registered carry-out of bit WIDTH-1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the next edge SHALL load A and B into shift registers, clear the carry flop, zero the bit counter and enter RUN.
REQ-015 RUN SHALL last exactly WIDTH cycles; each cycle processes one bit, LSB first, through a single fa_cell, shifts the sum bit in and updates the carry flop.
REQ-016 On the edge completing bit WIDTH-1, sum/carry SHALL load from the shift register and carry flop, and the FSM SHALL enter DONE.
REQ-017 Latency SHALL be fixed: start accepted at edge k gives done=1 after edge k+WIDTH.
REQ-018 sum and carry SHALL hold the previous result throughout RUN and IDLE; no partial values SHALL be visible.
REQ-019 In DONE with ack=1, the next edge SHALL return to IDLE; DONE SHALL otherwise hold indefinitely with stable outputs.
REQ-020 start SHALL be ignored in RUN and DONE; ack SHALL be ignored in IDLE and RUN.
REQ-021 If start and ack are both high in DONE, ack SHALL be honoured and start dropped; a new start is accepted from IDLE on the following cycle at the earliest.
REQ-022 Changes on A, B or sub after acceptance SHALL have no effect on the current operation.
REQ-023 Overflow SHALL wrap: sum = (A+B) mod 2^WIDTH, carry = bit WIDTH of A+B.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, busy=0, done=0, sum=0, carry=0, and clear the counter, shift registers and carry flop.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after release is accepted on the next edge.

Configuration
REQ-026 With macro SERIAL_ADD_SUB_EN defined, port sub SHALL exist; sub=1 SHALL invert the B bit into fa_cell and preset the carry flop to 1, so sum = (A-B) mod 2^WIDTH and carry=1 means no borrow (A>=B).
REQ-027 Without SERIAL_ADD_SUB_EN, there SHALL be no sub port and no inversion logic, and the block SHALL add only.

Structure
REQ-028 Package serial_add_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the counter-width constant, clog2 of the maximum WIDTH.
REQ-029 Sub-module fa_cell SHALL be a 1-bit full adder built from two HA instances plus an OR of their carries; it SHALL be the only arithmetic resource.

Verification
REQ-030 The bench SHALL check reset: rst_n pulsed low mid-RUN -> busy, done, sum and carry all 0 before the next clk edge, and no later done.
REQ-031 The bench SHALL check a basic add: A=8'h35, B=8'h0A, start -> done exactly 8 cycles after acceptance, sum=8'h3F, carry=0.
REQ-032 The bench SHALL check wrap-around: A=8'hFF, B=8'h01 -> sum=8'h00, carry=1.
REQ-033 The bench SHALL check handshakes: start held high through RUN -> single operation only; ack and start together in DONE -> IDLE, second operation accepted one cycle later, sum from the prior result held during its RUN.
REQ-034 The bench SHALL check a stall: ack held low for 20 cycles in DONE -> done=1 and sum/carry unchanged throughout.
REQ-035 With SERIAL_ADD_SUB_EN, the bench SHALL check A=8'h05, B=8'h07, sub=1 -> sum=8'hFE, carry=0; and A=8'h07, B=8'h05, sub=1 -> sum=8'h02, carry=1.
